// File: rtl/video_timing_controller.sv
// Pixel-clock raster sequencer for the DVI path: registered fetch requests run PIX_LAT cycles
// ahead of de/hsync/vsync so the pixel source pipeline is hidden from the encoders.
module video_timing_controller #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIX_LAT  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic        o_pix_req,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_frame_start,
  output logic        o_line_start,
  output logic        o_de,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [1:0]  o_ctrl0,
  output logic [1:0]  o_ctrl1,
  output logic [1:0]  o_ctrl2
);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_t;

  localparam logic [11:0] H_ACT_M1  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] H_FP_M1   = 12'(H_FP - 1);
  localparam logic [11:0] H_SYNC_M1 = 12'(H_SYNC - 1);
  localparam logic [11:0] H_BP_M1   = 12'(H_BP - 1);
  localparam logic [11:0] V_ACT_M1  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] V_FP_M1   = 12'(V_FP - 1);
  localparam logic [11:0] V_SYNC_M1 = 12'(V_SYNC - 1);
  localparam logic [11:0] V_BP_M1   = 12'(V_BP - 1);

  phase_t      r_hState, w_hStateNxt, r_vState, w_vStateNxt;
  logic [11:0] r_hPhase, w_hPhaseNxt, r_vPhase, w_vPhaseNxt;
  logic [11:0] r_hCnt, w_hCntNxt, r_vCnt, w_vCntNxt;
  logic [11:0] w_hLastIdx, w_vLastIdx;
  logic        w_hLast, w_vLast, w_hWrap;
  logic        w_pixReq, w_frameStart, w_lineStart, w_hsRaw, w_vsRaw;
  logic        r_pixReq, r_frameStart, r_lineStart, r_hsRaw, r_vsRaw;
  logic [11:0] r_x, r_y;
  logic        w_deOut, w_hsOut, w_vsOut;

  function automatic phase_t nextPhase(input phase_t p);
    case (p)
      PH_ACTIVE: return PH_FP;
      PH_FP:     return PH_SYNC;
      PH_SYNC:   return PH_BP;
      default:   return PH_ACTIVE;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hState <= PH_ACTIVE;
      r_vState <= PH_ACTIVE;
      r_hPhase <= '0;
      r_vPhase <= '0;
      r_hCnt   <= '0;
      r_vCnt   <= '0;
    end else begin
      r_hState <= w_hStateNxt;
      r_vState <= w_vStateNxt;
      r_hPhase <= w_hPhaseNxt;
      r_vPhase <= w_vPhaseNxt;
      r_hCnt   <= w_hCntNxt;
      r_vCnt   <= w_vCntNxt;
    end
  end

  // The vertical machine only moves on the cycle the horizontal one wraps BP -> ACTIVE.
  always_comb begin
    case (r_hState)
      PH_FP:   w_hLastIdx = H_FP_M1;
      PH_SYNC: w_hLastIdx = H_SYNC_M1;
      PH_BP:   w_hLastIdx = H_BP_M1;
      default: w_hLastIdx = H_ACT_M1;
    endcase
    case (r_vState)
      PH_FP:   w_vLastIdx = V_FP_M1;
      PH_SYNC: w_vLastIdx = V_SYNC_M1;
      PH_BP:   w_vLastIdx = V_BP_M1;
      default: w_vLastIdx = V_ACT_M1;
    endcase
    w_hLast = (r_hPhase == w_hLastIdx);
    w_vLast = (r_vPhase == w_vLastIdx);
    w_hWrap = w_hLast && (r_hState == PH_BP);

    w_hStateNxt = r_hState;
    w_hPhaseNxt = r_hPhase + 12'd1;
    w_hCntNxt   = r_hCnt + 12'd1;
    w_vStateNxt = r_vState;
    w_vPhaseNxt = r_vPhase;
    w_vCntNxt   = r_vCnt;
    if (w_hLast) begin
      w_hStateNxt = nextPhase(r_hState);
      w_hPhaseNxt = '0;
    end
    if (w_hWrap) begin
      w_hCntNxt   = '0;
      w_vPhaseNxt = r_vPhase + 12'd1;
      w_vCntNxt   = r_vCnt + 12'd1;
      if (w_vLast) begin
        w_vStateNxt = nextPhase(r_vState);
        w_vPhaseNxt = '0;
        if (r_vState == PH_BP) w_vCntNxt = '0;
      end
    end
    if (!i_en) begin
      w_hStateNxt = PH_ACTIVE;
      w_vStateNxt = PH_ACTIVE;
      w_hPhaseNxt = '0;
      w_vPhaseNxt = '0;
      w_hCntNxt   = '0;
      w_vCntNxt   = '0;
    end
  end

  always_comb begin
    w_pixReq     = i_en && (r_hState == PH_ACTIVE) && (r_vState == PH_ACTIVE);
    w_frameStart = i_en && (r_hCnt == 12'd0) && (r_vCnt == 12'd0);
    w_lineStart  = i_en && (r_hCnt == 12'd0) && (r_vState == PH_ACTIVE);
    w_hsRaw      = i_en && (r_hState == PH_SYNC);
    w_vsRaw      = i_en && (r_vState == PH_SYNC);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pixReq     <= 1'b0;
      r_frameStart <= 1'b0;
      r_lineStart  <= 1'b0;
      r_hsRaw      <= 1'b0;
      r_vsRaw      <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
    end else begin
      r_pixReq     <= w_pixReq;
      r_frameStart <= w_frameStart;
      r_lineStart  <= w_lineStart;
      r_hsRaw      <= w_hsRaw;
      r_vsRaw      <= w_vsRaw;
      if (w_pixReq) begin
        r_x <= r_hCnt;
        r_y <= r_vCnt;
      end
    end
  end

  generate
    if (PIX_LAT == 0) begin : g_noDelay
      assign {w_deOut, w_hsOut, w_vsOut} = {r_pixReq, r_hsRaw, r_vsRaw};
    end else begin : g_delay
      logic [PIX_LAT-1:0][2:0] r_dly;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_dly <= '0;
        end else begin
          r_dly[0] <= {r_pixReq, r_hsRaw, r_vsRaw};
          for (int i = 1; i < PIX_LAT; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign {w_deOut, w_hsOut, w_vsOut} = r_dly[PIX_LAT-1];
    end
  endgenerate

  assign o_pix_req     = r_pixReq;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_frame_start = r_frameStart;
  assign o_line_start  = r_lineStart;
  assign o_de          = w_deOut;
  assign o_hsync       = w_hsOut ? HS_POL : ~HS_POL;
  assign o_vsync       = w_vsOut ? VS_POL : ~VS_POL;
  assign o_ctrl0       = {o_vsync, o_hsync};
  assign o_ctrl1       = 2'b00;
  assign o_ctrl2       = 2'b00;

endmodule

// File: tb/tb_video_timing_controller.sv
// Self-checking bench: three raster configurations compared every cycle against a
// position-since-enable arithmetic model of the fetch and display outputs.
module tb_video_timing_controller;

  typedef struct packed {
    logic        req;
    logic        fs;
    logic        ls;
    logic        hs;
    logic        vs;
    logic [11:0] x;
    logic [11:0] y;
  } exp_t;

  localparam int PA [8] = '{4, 1, 2, 1, 3, 1, 1, 1};
  localparam int PB [8] = '{12, 3, 4, 5, 6, 2, 2, 3};
  localparam int PC [8] = '{160, 8, 16, 16, 60, 3, 2, 5};
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;
  localparam int LAT_C = 5;
  localparam int HT_A = PA[0] + PA[1] + PA[2] + PA[3];
  localparam int VT_A = PA[4] + PA[5] + PA[6] + PA[7];
  localparam int HT_B = PB[0] + PB[1] + PB[2] + PB[3];
  localparam int VT_B = PB[4] + PB[5] + PB[6] + PB[7];
  localparam int HT_C = PC[0] + PC[1] + PC[2] + PC[3];
  localparam int VT_C = PC[4] + PC[5] + PC[6] + PC[7];
  localparam int FR_A = HT_A * VT_A;
  localparam int FR_B = HT_B * VT_B;
  localparam int FR_C = HT_C * VT_C;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rstN = 1'b1;
  logic enA, enB, enC;
  logic reqA, fsA, lsA, deA, hsA, vsA;
  logic reqB, fsB, lsB, deB, hsB, vsB;
  logic reqC, fsC, lsC, deC, hsC, vsC;
  logic [11:0] xA, yA, xB, yB, xC, yC;
  logic [1:0] c0A, c1A, c2A, c0B, c1B, c2B, c0C, c1C, c2C;
  logic [26:0] fetchA, fetchB, fetchC, expFetchA, expFetchB, expFetchC;
  logic [8:0] dispA, dispB, dispC, expDispA, expDispB, expDispC;

  always #5 clk = ~clk;

  video_timing_controller #(.H_ACTIVE(PA[0]), .H_FP(PA[1]), .H_SYNC(PA[2]), .H_BP(PA[3]),
    .V_ACTIVE(PA[4]), .V_FP(PA[5]), .V_SYNC(PA[6]), .V_BP(PA[7]),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(LAT_A)) dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_en(enA), .o_pix_req(reqA), .o_x(xA), .o_y(yA),
    .o_frame_start(fsA), .o_line_start(lsA), .o_de(deA), .o_hsync(hsA), .o_vsync(vsA),
    .o_ctrl0(c0A), .o_ctrl1(c1A), .o_ctrl2(c2A));

  video_timing_controller #(.H_ACTIVE(PB[0]), .H_FP(PB[1]), .H_SYNC(PB[2]), .H_BP(PB[3]),
    .V_ACTIVE(PB[4]), .V_FP(PB[5]), .V_SYNC(PB[6]), .V_BP(PB[7]),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(LAT_B)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_en(enB), .o_pix_req(reqB), .o_x(xB), .o_y(yB),
    .o_frame_start(fsB), .o_line_start(lsB), .o_de(deB), .o_hsync(hsB), .o_vsync(vsB),
    .o_ctrl0(c0B), .o_ctrl1(c1B), .o_ctrl2(c2B));

  video_timing_controller #(.H_ACTIVE(PC[0]), .H_FP(PC[1]), .H_SYNC(PC[2]), .H_BP(PC[3]),
    .V_ACTIVE(PC[4]), .V_FP(PC[5]), .V_SYNC(PC[6]), .V_BP(PC[7]),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(LAT_C)) dutC (
    .i_clk(clk), .i_rst_n(rstN), .i_en(enC), .o_pix_req(reqC), .o_x(xC), .o_y(yC),
    .o_frame_start(fsC), .o_line_start(lsC), .o_de(deC), .o_hsync(hsC), .o_vsync(vsC),
    .o_ctrl0(c0C), .o_ctrl1(c1C), .o_ctrl2(c2C));

  assign fetchA = {reqA, fsA, lsA, xA, yA};
  assign fetchB = {reqB, fsB, lsB, xB, yB};
  assign fetchC = {reqC, fsC, lsC, xC, yC};
  assign dispA  = {deA, hsA, vsA, c0A, c1A, c2A};
  assign dispB  = {deB, hsB, vsB, c0B, c1B, c2B};
  assign dispC  = {deC, hsC, vsC, c0C, c1C, c2C};

  // t is the number of cycles since enable rose; -1 means blanking.
  function automatic exp_t model(input int t, input int p[8]);
    exp_t e;
    int ht, vt, h, v;
    e = '0;
    if (t >= 0) begin
      ht = p[0] + p[1] + p[2] + p[3];
      vt = p[4] + p[5] + p[6] + p[7];
      h = t % ht;
      v = (t / ht) % vt;
      e.req = (h < p[0]) && (v < p[4]);
      e.fs  = (h == 0) && (v == 0);
      e.ls  = (h == 0) && (v < p[4]);
      e.hs  = (h >= p[0] + p[1]) && (h < p[0] + p[1] + p[2]);
      e.vs  = (v >= p[4] + p[5]) && (v < p[4] + p[5] + p[6]);
      e.x   = 12'(h);
      e.y   = 12'(v);
    end
    return e;
  endfunction

  function automatic logic [8:0] dispOf(input exp_t d, input logic hp, input logic vp);
    logic h, v;
    h = d.hs ? hp : ~hp;
    v = d.vs ? vp : ~vp;
    return {d.req, h, v, v, h, 4'b0000};
  endfunction

  int tA, tB, tC;
  int hA [16];
  int hB [16];
  int hC [16];
  logic [11:0] mxA, myA, mxB, myB, mxC, myC;

  always @(posedge clk or negedge rstN) begin
    exp_t e;
    if (!rstN) begin
      tA = -1;
      for (int i = 0; i < 16; i++) hA[i] = -1;
      mxA = '0;
      myA = '0;
    end else begin
      tA = enA ? tA + 1 : -1;
      for (int i = 15; i > 0; i--) hA[i] = hA[i-1];
      hA[0] = tA;
    end
    e = model(tA, PA);
    if (e.req) begin
      mxA = e.x;
      myA = e.y;
    end
    expFetchA = {e.req, e.fs, e.ls, mxA, myA};
    expDispA = dispOf(model(hA[LAT_A], PA), 1'b0, 1'b0);
  end

  always @(posedge clk or negedge rstN) begin
    exp_t e;
    if (!rstN) begin
      tB = -1;
      for (int i = 0; i < 16; i++) hB[i] = -1;
      mxB = '0;
      myB = '0;
    end else begin
      tB = enB ? tB + 1 : -1;
      for (int i = 15; i > 0; i--) hB[i] = hB[i-1];
      hB[0] = tB;
    end
    e = model(tB, PB);
    if (e.req) begin
      mxB = e.x;
      myB = e.y;
    end
    expFetchB = {e.req, e.fs, e.ls, mxB, myB};
    expDispB = dispOf(model(hB[LAT_B], PB), 1'b1, 1'b1);
  end

  always @(posedge clk or negedge rstN) begin
    exp_t e;
    if (!rstN) begin
      tC = -1;
      for (int i = 0; i < 16; i++) hC[i] = -1;
      mxC = '0;
      myC = '0;
    end else begin
      tC = enC ? tC + 1 : -1;
      for (int i = 15; i > 0; i--) hC[i] = hC[i-1];
      hC[0] = tC;
    end
    e = model(tC, PC);
    if (e.req) begin
      mxC = e.x;
      myC = e.y;
    end
    expFetchC = {e.req, e.fs, e.ls, mxC, myC};
    expDispC = dispOf(model(hC[LAT_C], PC), 1'b0, 1'b0);
  end

  task automatic test_reset;
    enA = 1'b1;
    enB = 1'b1;
    enC = 1'b1;
    repeat (20 + $urandom_range(0, 20)) @(negedge clk);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({deA, reqA, xA, yA, c0A} !== {1'b0, 1'b0, 12'd0, 12'd0, 2'b11}) begin
      errors++;
      $display("FAIL reset_async_A got=%h exp=%h", {deA, reqA, xA, yA, c0A}, {1'b0, 1'b0, 12'd0, 12'd0, 2'b11});
    end
    checks++;
    if ({deB, reqB, fsB, lsB, c0B} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_pol_B got=%b exp=000000", {deB, reqB, fsB, lsB, c0B});
    end
    checks++;
    if ({fsC, lsC, deC, c0C, c1C, c2C} !== {3'b000, 2'b11, 4'b0000}) begin
      errors++;
      $display("FAIL reset_C got=%b exp=000110000", {fsC, lsC, deC, c0C, c1C, c2C});
    end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checks++;
    if ({fsA, reqA, xA, yA} !== {1'b1, 1'b1, 12'd0, 12'd0}) begin
      errors++;
      $display("FAIL reset_first_frame got=%h exp=%h", {fsA, reqA, xA, yA}, {1'b1, 1'b1, 12'd0, 12'd0});
    end
  endtask

  task automatic test_small_raster;
    int reqCount = 0;
    for (int c = 0; c < 3 * FR_A; c++) begin
      @(negedge clk);
      checks++;
      if (fetchA !== expFetchA) begin
        errors++;
        $display("FAIL small_fetch cyc=%0d got=%h exp=%h", c, fetchA, expFetchA);
      end
      checks++;
      if (dispA !== expDispA) begin
        errors++;
        $display("FAIL small_disp cyc=%0d got=%b exp=%b", c, dispA, expDispA);
      end
      if (reqA === 1'b1) reqCount++;
    end
    checks++;
    if (reqCount !== 3 * PA[0] * PA[4]) begin
      errors++;
      $display("FAIL small_req_count got=%0d exp=%0d", reqCount, 3 * PA[0] * PA[4]);
    end
  endtask

  task automatic test_polarity;
    int hsHigh = 0;
    int vsHigh = 0;
    for (int c = 0; c < FR_B; c++) begin
      @(negedge clk);
      checks++;
      if (dispB !== expDispB) begin
        errors++;
        $display("FAIL pol_disp cyc=%0d got=%b exp=%b", c, dispB, expDispB);
      end
      if (hsB === 1'b1) hsHigh++;
      if (vsB === 1'b1) vsHigh++;
    end
    checks++;
    if (hsHigh !== PB[2] * VT_B) begin
      errors++;
      $display("FAIL pol_hs_count got=%0d exp=%0d", hsHigh, PB[2] * VT_B);
    end
    checks++;
    if (vsHigh !== PB[6] * HT_B) begin
      errors++;
      $display("FAIL pol_vs_count got=%0d exp=%0d", vsHigh, PB[6] * HT_B);
    end
  endtask

  task automatic test_pixlat0;
    int lsCount = 0;
    int fsCount = 0;
    for (int c = 0; c < FR_B; c++) begin
      @(negedge clk);
      checks++;
      if (fetchB !== expFetchB) begin
        errors++;
        $display("FAIL lat0_fetch cyc=%0d got=%h exp=%h", c, fetchB, expFetchB);
      end
      checks++;
      if (deB !== expFetchB[26]) begin
        errors++;
        $display("FAIL lat0_de cyc=%0d got=%b exp=%b", c, deB, expFetchB[26]);
      end
      if (lsB === 1'b1) lsCount++;
      if (fsB === 1'b1) fsCount++;
    end
    checks++;
    if ({lsCount, fsCount} !== {PB[4], 32'd1}) begin
      errors++;
      $display("FAIL lat0_line_count got=%0d/%0d exp=%0d/1", lsCount, fsCount, PB[4]);
    end
  endtask

  task automatic test_frame_wrap;
    int fsCount = 0;
    int reqCount = 0;
    int lastFs = -1;
    logic [11:0] px = '0;
    logic [11:0] py = '0;
    bit seen = 1'b0;
    for (int c = 0; c < 2 * FR_C; c++) begin
      @(negedge clk);
      checks++;
      if (fetchC !== expFetchC) begin
        errors++;
        $display("FAIL wrap_fetch cyc=%0d got=%h exp=%h", c, fetchC, expFetchC);
      end
      checks++;
      if (dispC !== expDispC) begin
        errors++;
        $display("FAIL wrap_disp cyc=%0d got=%b exp=%b", c, dispC, expDispC);
      end
      if (fsC === 1'b1) begin
        if (lastFs >= 0) begin
          checks++;
          if (c - lastFs !== FR_C) begin
            errors++;
            $display("FAIL wrap_period got=%0d exp=%0d", c - lastFs, FR_C);
          end
        end
        if (seen) begin
          checks++;
          if ({px, py} !== {12'(PC[0] - 1), 12'(PC[4] - 1)}) begin
            errors++;
            $display("FAIL wrap_last_fetch got=%0d,%0d exp=%0d,%0d", px, py, PC[0] - 1, PC[4] - 1);
          end
        end
        lastFs = c;
        fsCount++;
      end
      if (reqC === 1'b1) begin
        reqCount++;
        px = xC;
        py = yC;
        seen = 1'b1;
      end
    end
    checks++;
    if ({fsCount, reqCount} !== {32'd2, 2 * PC[0] * PC[4]}) begin
      errors++;
      $display("FAIL wrap_counts got=%0d/%0d exp=2/%0d", fsCount, reqCount, 2 * PC[0] * PC[4]);
    end
  endtask

  task automatic test_en_drop;
    int target = 50 * HT_C + 100;
    enC = 1'b0;
    @(negedge clk);
    enC = 1'b1;
    @(negedge clk);
    checks++;
    if ({fsC, reqC, xC, yC} !== {1'b1, 1'b1, 12'd0, 12'd0}) begin
      errors++;
      $display("FAIL endrop_restart got=%h exp=%h", {fsC, reqC, xC, yC}, {1'b1, 1'b1, 12'd0, 12'd0});
    end
    for (int c = 1; c <= target; c++) begin
      @(negedge clk);
      checks++;
      if ({fetchC, dispC} !== {expFetchC, expDispC}) begin
        errors++;
        $display("FAIL endrop_run cyc=%0d got=%h exp=%h", c, {fetchC, dispC}, {expFetchC, expDispC});
      end
    end
    checks++;
    if ({reqC, xC, yC} !== {1'b1, 12'd100, 12'd50}) begin
      errors++;
      $display("FAIL endrop_position got=%h exp=%h", {reqC, xC, yC}, {1'b1, 12'd100, 12'd50});
    end
    enC = 1'b0;
    @(negedge clk);
    checks++;
    if ({reqC, fsC, lsC} !== 3'b000) begin
      errors++;
      $display("FAIL endrop_req got=%b exp=000", {reqC, fsC, lsC});
    end
    for (int c = 0; c < LAT_C; c++) begin
      @(negedge clk);
      checks++;
      if (dispC !== expDispC) begin
        errors++;
        $display("FAIL endrop_drain cyc=%0d got=%b exp=%b", c, dispC, expDispC);
      end
    end
    checks++;
    if ({deC, c0C} !== {1'b0, 2'b11}) begin
      errors++;
      $display("FAIL endrop_drained got=%b exp=011", {deC, c0C});
    end
    enC = 1'b1;
    @(negedge clk);
    checks++;
    if ({fsC, reqC, xC, yC} !== {1'b1, 1'b1, 12'd0, 12'd0}) begin
      errors++;
      $display("FAIL endrop_return got=%h exp=%h", {fsC, reqC, xC, yC}, {1'b1, 1'b1, 12'd0, 12'd0});
    end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 1500; c++) begin
      enA = ($urandom_range(0, 11) != 0);
      enB = ($urandom_range(0, 11) != 0);
      enC = ($urandom_range(0, 11) != 0);
      @(negedge clk);
      checks++;
      if ({fetchA, dispA} !== {expFetchA, expDispA}) begin
        errors++;
        $display("FAIL random_A cyc=%0d got=%h exp=%h", c, {fetchA, dispA}, {expFetchA, expDispA});
      end
      checks++;
      if ({fetchB, dispB} !== {expFetchB, expDispB}) begin
        errors++;
        $display("FAIL random_B cyc=%0d got=%h exp=%h", c, {fetchB, dispB}, {expFetchB, expDispB});
      end
      checks++;
      if ({fetchC, dispC} !== {expFetchC, expDispC}) begin
        errors++;
        $display("FAIL random_C cyc=%0d got=%h exp=%h", c, {fetchC, dispC}, {expFetchC, expDispC});
      end
    end
  endtask

  initial begin
    enA = 1'b0;
    enB = 1'b0;
    enC = 1'b0;
    #2 rstN = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    test_reset;
    test_small_raster;
    test_polarity;
    test_pixlat0;
    test_frame_wrap;
    test_en_drop;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
